// File: rtl/core_mdu_pkg.sv
// Shared definitions for the execute-stage MDU issue/retire controller:
// one-hot op bit positions, op vector width and the controller state type.
package core_mdu_pkg;

   localparam int MDU_OP_W = 8;

   localparam int MDU_OP_MUL    = 0;
   localparam int MDU_OP_MULH   = 1;
   localparam int MDU_OP_MULHU  = 2;
   localparam int MDU_OP_MULHSU = 3;
   localparam int MDU_OP_DIV    = 4;
   localparam int MDU_OP_DIVU   = 5;
   localparam int MDU_OP_REM    = 6;
   localparam int MDU_OP_REMU   = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HOLD
   } mdu_state_e;

endpackage

// File: rtl/core_mdu_fastpath.sv
// RISC-V divide special cases (divide by zero, signed overflow) resolved
// combinationally so they never occupy the iterative MDU.
module core_mdu_fastpath
   import core_mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [MDU_OP_W-1:0] op,
   input  logic                word,
   input  logic [XLEN-1:0]     rs1,
   input  logic [XLEN-1:0]     rs2,
   output logic                hit,
   output logic [XLEN-1:0]     result
);

   logic            is_mul;
   logic            is_div;
   logic            is_rem;
   logic            is_signed;
   logic            div_zero;
   logic            overflow;
   logic [XLEN-1:0] dividend;

   always_comb begin
      is_mul    = |op[MDU_OP_MULHSU:MDU_OP_MUL];
      is_div    = op[MDU_OP_DIV] | op[MDU_OP_DIVU];
      is_rem    = op[MDU_OP_REM] | op[MDU_OP_REMU];
      is_signed = op[MDU_OP_DIV] | op[MDU_OP_REM];

      // Word ops look only at the low halves; the dividend is returned sign-extended.
      if (word) begin
         dividend = {{(XLEN-32){rs1[31]}}, rs1[31:0]};
         div_zero = (rs2[31:0] == 32'd0);
         overflow = (rs1[31:0] == 32'h8000_0000) && (rs2[31:0] == 32'hFFFF_FFFF);
      end else begin
         dividend = rs1;
         div_zero = (rs2 == '0);
         overflow = (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
      end

      // NOTE: outputs get a default before the branches so no path infers a latch.
      hit    = 1'b0;
      result = '0;
      if (!is_mul) begin
         if (div_zero && (is_div || is_rem)) begin
            hit    = 1'b1;
            result = is_div ? '1 : dividend;
         end else if (overflow && is_signed) begin
            hit    = 1'b1;
            result = is_div ? dividend : '0;
         end
      end
   end

endmodule

// File: rtl/core_pipe_exec_mdu_ctrl.sv
// Execute-stage MDU controller: latches one op, holds it on the MDU until
// ready, then holds the (sign-extended) result for writeback.
module core_pipe_exec_mdu_ctrl
   import core_mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic                g_clk,
   input  logic                g_reset,
   input  logic                flush,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [MDU_OP_W-1:0] s_op,
   input  logic                s_word,
   input  logic [XLEN-1:0]     s_rs1,
   input  logic [XLEN-1:0]     s_rs2,
   input  logic [4:0]          s_rd_addr,
   output logic                mdu_valid,
   output logic [MDU_OP_W-1:0] mdu_op,
   output logic                mdu_word,
   output logic [XLEN-1:0]     mdu_rs1,
   output logic [XLEN-1:0]     mdu_rs2,
   output logic                mdu_flush,
   input  logic                mdu_ready,
   input  logic [XLEN-1:0]     mdu_rd,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [4:0]          wb_rd_addr,
   output logic [XLEN-1:0]     wb_data,
   output logic                busy
);

   mdu_state_e      state;
   logic            fast_hit;
   logic [XLEN-1:0] fast_result;
   logic            accept;
   logic            complete;

   core_mdu_fastpath #(.XLEN(XLEN)) u_fastpath (
      .op     (s_op),
      .word   (s_word),
      .rs1    (s_rs1),
      .rs2    (s_rs2),
      .hit    (fast_hit),
      .result (fast_result)
   );

   // HOLD can retire and accept in the same cycle, hence the wb_ready term.
   assign s_ready   = !flush && ((state == ST_IDLE) || ((state == ST_HOLD) && wb_ready));
   assign accept    = s_valid && s_ready;
   assign complete  = (state == ST_RUN) && mdu_ready;
   assign mdu_flush = g_reset || flush || complete;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state      <= ST_IDLE;
         mdu_valid  <= 1'b0;
         wb_valid   <= 1'b0;
         busy       <= 1'b0;
         mdu_op     <= '0;
         mdu_word   <= 1'b0;
         mdu_rs1    <= '0;
         mdu_rs2    <= '0;
         wb_rd_addr <= '0;
         wb_data    <= '0;
      end else if (flush) begin
         state     <= ST_IDLE;
         mdu_valid <= 1'b0;
         wb_valid  <= 1'b0;
         busy      <= 1'b0;
      end else if (accept) begin
         mdu_op     <= s_op;
         mdu_word   <= s_word;
         mdu_rs1    <= s_rs1;
         mdu_rs2    <= s_rs2;
         wb_rd_addr <= s_rd_addr;
         busy       <= 1'b1;
         if (fast_hit) begin
            state     <= ST_HOLD;
            mdu_valid <= 1'b0;
            wb_valid  <= 1'b1;
            wb_data   <= fast_result;
         end else begin
            state     <= ST_RUN;
            mdu_valid <= 1'b1;
            wb_valid  <= 1'b0;
         end
      end else if (complete) begin
         state     <= ST_HOLD;
         mdu_valid <= 1'b0;
         wb_valid  <= 1'b1;
         wb_data   <= mdu_word ? {{(XLEN-32){mdu_rd[31]}}, mdu_rd[31:0]} : mdu_rd;
      end else if ((state == ST_HOLD) && wb_ready) begin
         state    <= ST_IDLE;
         wb_valid <= 1'b0;
         busy     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_core_pipe_exec_mdu_ctrl.sv
// Self-checking bench: directed cases plus random ops checked against a
// RISC-V M-extension reference model; the bench also plays the MDU.
module tb_core_pipe_exec_mdu_ctrl;
   import core_mdu_pkg::*;

   localparam int XLEN = 64;

   logic            g_clk = 1'b0;
   logic            g_reset, flush, s_valid, s_word, mdu_ready, wb_ready;
   logic [7:0]      s_op;
   logic [63:0]     s_rs1, s_rs2, mdu_rd;
   logic [4:0]      s_rd_addr;
   logic            s_ready, mdu_valid, mdu_word, mdu_flush, wb_valid, busy;
   logic [7:0]      mdu_op;
   logic [63:0]     mdu_rs1, mdu_rs2, wb_data;
   logic [4:0]      wb_rd_addr;

   int checks = 0;
   int errors = 0;
   int flush_pulses = 0;
   int valid_cycles = 0;

   core_pipe_exec_mdu_ctrl #(.XLEN(XLEN)) dut (
      .g_clk      (g_clk),
      .g_reset    (g_reset),
      .flush      (flush),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_op       (s_op),
      .s_word     (s_word),
      .s_rs1      (s_rs1),
      .s_rs2      (s_rs2),
      .s_rd_addr  (s_rd_addr),
      .mdu_valid  (mdu_valid),
      .mdu_op     (mdu_op),
      .mdu_word   (mdu_word),
      .mdu_rs1    (mdu_rs1),
      .mdu_rs2    (mdu_rs2),
      .mdu_flush  (mdu_flush),
      .mdu_ready  (mdu_ready),
      .mdu_rd     (mdu_rd),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd_addr (wb_rd_addr),
      .wb_data    (wb_data),
      .busy       (busy)
   );

   always #5 g_clk = ~g_clk;

   always @(negedge g_clk) begin
      if (mdu_flush) flush_pulses++;
      if (mdu_valid) valid_cycles++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   // Architectural result of an M-extension op, straight from the ISA rules.
   function automatic logic [63:0] ref_m(input int op, input bit word,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [63:0]  r;
      logic [31:0]  a32, b32, r32;
      a32 = a[31:0];
      b32 = b[31:0];
      r   = '0;
      r32 = '0;
      if (word) begin
         case (op)
            MDU_OP_MUL:  r32 = a32 * b32;
            MDU_OP_DIV:  if (b32 == 0) r32 = '1;
                         else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                         else r32 = $signed(a32) / $signed(b32);
            MDU_OP_DIVU: r32 = (b32 == 0) ? '1 : a32 / b32;
            MDU_OP_REM:  if (b32 == 0) r32 = a32;
                         else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                         else r32 = $signed(a32) % $signed(b32);
            MDU_OP_REMU: r32 = (b32 == 0) ? a32 : a32 % b32;
            default:     r32 = '0;
         endcase
         r = {{32{r32[31]}}, r32};
      end else begin
         case (op)
            MDU_OP_MUL:    r = a * b;
            MDU_OP_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            MDU_OP_MULHU:  begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
            MDU_OP_MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
            MDU_OP_DIV:    if (b == 0) r = '1;
                           else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                           else r = $signed(a) / $signed(b);
            MDU_OP_DIVU:   r = (b == 0) ? '1 : a / b;
            MDU_OP_REM:    if (b == 0) r = a;
                           else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                           else r = $signed(a) % $signed(b);
            MDU_OP_REMU:   r = (b == 0) ? a : a % b;
            default:       r = '0;
         endcase
      end
      return r;
   endfunction

   // Divide-family ops with a zero divisor or signed overflow never reach the MDU.
   function automatic bit expect_fast(input int op, input bit word,
                                      input logic [63:0] a, input logic [63:0] b);
      bit zero, ovf;
      if (op < MDU_OP_DIV) return 1'b0;
      zero = word ? (b[31:0] == 0) : (b == 0);
      ovf  = word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                  : (a == 64'h8000_0000_0000_0000 && b == '1);
      return zero || (ovf && (op == MDU_OP_DIV || op == MDU_OP_REM));
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return {$urandom(), 32'h8000_0000};
         4:       return {$urandom(), 32'hFFFF_FFFF};
         5:       return {$urandom(), 32'h0};
         6:       return {32'd0, $urandom()};
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   // One op from IDLE to retirement; lat = MDU wait cycles, bp = wb stall cycles.
   task automatic run_op(input string tag, input int op, input bit word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input int lat, input int bp);
      logic [63:0] exp;
      logic [7:0]  op_vec;
      bit          fast;
      int          f0, v0;
      exp    = ref_m(op, word, a, b);
      fast   = expect_fast(op, word, a, b);
      op_vec = 8'd1 << op;
      check({tag, ".s_ready_idle"}, s_ready, 1'b1);
      f0 = flush_pulses;
      v0 = valid_cycles;
      s_valid = 1'b1; s_op = op_vec; s_word = word; s_rs1 = a; s_rs2 = b; s_rd_addr = rd;
      step();
      s_valid = 1'b0; s_op = '0; s_rs1 = '0; s_rs2 = '0; s_rd_addr = '0; s_word = 1'b0;
      if (fast) begin
         check({tag, ".fast_mdu_valid"}, mdu_valid, 1'b0);
      end else begin
         check({tag, ".mdu_valid"}, mdu_valid, 1'b1);
         check({tag, ".mdu_op"}, mdu_op, op_vec);
         check({tag, ".mdu_rs1"}, mdu_rs1, a);
         check({tag, ".mdu_rs2"}, mdu_rs2, b);
         check({tag, ".mdu_word"}, mdu_word, word);
         repeat (lat) step();
         check({tag, ".run_wb_valid"}, wb_valid, 1'b0);
         check({tag, ".run_mdu_valid"}, mdu_valid, 1'b1);
         mdu_ready = 1'b1;
         mdu_rd    = word ? {$urandom(), exp[31:0]} : exp;
         #1;
         check({tag, ".mdu_flush_pulse"}, mdu_flush, 1'b1);
         step();
         mdu_ready = 1'b0;
         mdu_rd    = {$urandom(), $urandom()};
      end
      check({tag, ".wb_valid"}, wb_valid, 1'b1);
      check({tag, ".wb_data"}, wb_data, exp);
      check({tag, ".wb_rd_addr"}, wb_rd_addr, rd);
      check({tag, ".hold_mdu_flush"}, mdu_flush, 1'b0);
      for (int i = 0; i < bp; i++) begin
         step();
         check({tag, ".bp_wb_data"}, wb_data, exp);
         check({tag, ".bp_s_ready"}, s_ready, 1'b0);
      end
      wb_ready = 1'b1;
      #1;
      check({tag, ".hold_s_ready"}, s_ready, 1'b1);
      step();
      wb_ready = 1'b0;
      check({tag, ".retired_busy"}, busy, 1'b0);
      check({tag, ".retired_wb_valid"}, wb_valid, 1'b0);
      check({tag, ".flush_pulses"}, 64'(flush_pulses - f0), fast ? 64'd0 : 64'd1);
      if (fast) check({tag, ".no_issue"}, 64'(valid_cycles - v0), 64'd0);
   endtask

   initial begin
      g_reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_word = 1'b0; s_op = '0;
      s_rs1 = '0; s_rs2 = '0; s_rd_addr = '0; mdu_ready = 1'b0; mdu_rd = '0; wb_ready = 1'b0;
      step();
      step();
      g_reset = 1'b0;
      #1;
      check("rst.s_ready", s_ready, 1'b1);
      check("rst.mdu_valid", mdu_valid, 1'b0);
      check("rst.mdu_flush", mdu_flush, 1'b0);
      check("rst.wb_valid", wb_valid, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.wb_data", wb_data, 64'd0);
      check("rst.wb_rd_addr", wb_rd_addr, 64'd0);
      check("rst.mdu_rs1", mdu_rs1, 64'd0);
      check("rst.mdu_op", mdu_op, 64'd0);

      run_op("mul",     MDU_OP_MUL,  1'b0, 64'd3, 64'd5, 5'd7, 16, 0);
      run_op("mulw",    MDU_OP_MUL,  1'b1, 64'h8000_0000, 64'd1, 5'd3, 4, 1);
      run_op("div0",    MDU_OP_DIV,  1'b0, 64'd7, 64'd0, 5'd1, 0, 0);
      run_op("remu0",   MDU_OP_REMU, 1'b0, 64'd7, 64'd0, 5'd2, 0, 0);
      run_op("divuw0",  MDU_OP_DIVU, 1'b1, 64'd5, 64'd0, 5'd4, 0, 0);
      run_op("ovf_div", MDU_OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 5'd5, 0, 0);
      run_op("ovf_rem", MDU_OP_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 5'd6, 0, 0);
      run_op("ovf_divw", MDU_OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd8, 0, 0);
      run_op("divw_norm", MDU_OP_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 3, 0);

      // Backpressure in HOLD with a waiting op, then back-to-back HOLD->RUN.
      s_valid = 1'b1; s_op = 8'd1; s_word = 1'b0; s_rs1 = 64'd9; s_rs2 = 64'd11; s_rd_addr = 5'd12;
      step();
      s_valid = 1'b0;
      check("bp.run", mdu_valid, 1'b1);
      mdu_ready = 1'b1; mdu_rd = 64'd99;
      step();
      mdu_ready = 1'b0;
      check("bp.hold_valid", wb_valid, 1'b1);
      s_valid = 1'b1; s_rs1 = 64'd4; s_rs2 = 64'd6; s_rd_addr = 5'd13;
      repeat (5) begin
         #1;
         check("bp.s_ready", s_ready, 1'b0);
         check("bp.wb_data", wb_data, 64'd99);
         check("bp.wb_rd_addr", wb_rd_addr, 64'd12);
         check("bp.wb_valid", wb_valid, 1'b1);
         step();
      end
      wb_ready = 1'b1;
      #1;
      check("b2b.s_ready", s_ready, 1'b1);
      step();
      wb_ready = 1'b0; s_valid = 1'b0;
      check("b2b.mdu_valid", mdu_valid, 1'b1);
      check("b2b.wb_valid", wb_valid, 1'b0);
      check("b2b.mdu_rs1", mdu_rs1, 64'd4);
      check("b2b.wb_rd_addr", wb_rd_addr, 64'd13);
      mdu_ready = 1'b1; mdu_rd = 64'd24;
      step();
      mdu_ready = 1'b0;
      check("b2b.wb_data", wb_data, 64'd24);
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
      check("b2b.idle", busy, 1'b0);

      // Flush mid-RUN.
      s_valid = 1'b1; s_op = 8'd1 << MDU_OP_DIVU; s_rs1 = 64'd100; s_rs2 = 64'd7; s_rd_addr = 5'd20;
      step();
      s_valid = 1'b0;
      step();
      check("flush.in_run", mdu_valid, 1'b1);
      flush = 1'b1;
      #1;
      check("flush.mdu_flush", mdu_flush, 1'b1);
      check("flush.s_ready", s_ready, 1'b0);
      step();
      flush = 1'b0;
      check("flush.busy", busy, 1'b0);
      check("flush.mdu_valid", mdu_valid, 1'b0);
      check("flush.wb_valid", wb_valid, 1'b0);
      step();
      check("flush.idle_mdu_flush", mdu_flush, 1'b0);
      check("flush.no_wb", wb_valid, 1'b0);

      // Flush with s_valid in IDLE: nothing accepted.
      flush = 1'b1; s_valid = 1'b1; s_op = 8'd1;
      #1;
      check("flush_idle.s_ready", s_ready, 1'b0);
      step();
      flush = 1'b0; s_valid = 1'b0;
      check("flush_idle.busy", busy, 1'b0);
      check("flush_idle.mdu_valid", mdu_valid, 1'b0);

      // Reset while holding a result.
      s_valid = 1'b1; s_op = 8'd1 << MDU_OP_DIV; s_rs1 = 64'd7; s_rs2 = 64'd0; s_rd_addr = 5'd21;
      step();
      s_valid = 1'b0;
      check("rst_hold.wb_valid_before", wb_valid, 1'b1);
      g_reset = 1'b1;
      step();
      g_reset = 1'b0;
      check("rst_hold.wb_valid", wb_valid, 1'b0);
      check("rst_hold.wb_data", wb_data, 64'd0);
      check("rst_hold.wb_rd_addr", wb_rd_addr, 64'd0);
      check("rst_hold.mdu_rs1", mdu_rs1, 64'd0);
      check("rst_hold.busy", busy, 1'b0);
      step();

      // Random ops against the reference model.
      for (int n = 0; n < 60; n++) begin
         int          op;
         bit          word;
         logic [63:0] a, b;
         op   = $urandom_range(0, 7);
         word = ($urandom_range(0, 2) == 0) &&
                !(op == MDU_OP_MULH || op == MDU_OP_MULHU || op == MDU_OP_MULHSU);
         a    = pick();
         b    = pick();
         run_op($sformatf("rnd%0d", n), op, word, a, b, 5'($urandom_range(0, 31)),
                $urandom_range(0, 20), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_pipe_exec_mdu_ctrl.md
# core_pipe_exec_mdu_ctrl

Issue/retire controller sitting directly upstream and downstream of the multiply-divide unit in the execute stage. It accepts one MDU instruction from the decode/execute pipeline register and holds operands and op stable on the MDU inputs until the MDU signals ready. It then captures and sign-extends the result and presents it to writeback with a valid/ready handshake. RISC-V divide special cases (divide-by-zero, signed overflow) are resolved locally in one cycle without issuing to the MDU.

## Interface
- `XLEN`, 64, data width. `XL = XLEN-1`.
- `g_clk`  in  1  clock.
- `g_reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill any in-flight operation.
- `s_valid`  in  1  upstream op valid.
- `s_ready`  out  1  controller accepts op this cycle.
- `s_op`  in  8  one-hot `{remu,rem,divu,div,mulhsu,mulhu,mulh,mul}`.
- `s_word`  in  1  32-bit word op (`*W`).
- `s_rs1`, `s_rs2`  in  XLEN  source operands.
- `s_rd_addr`  in  5  destination register.
- `mdu_valid`  out  1  operands valid to the MDU.
- `mdu_op`  out  8  latched op.
- `mdu_word`  out  1  latched word flag.
- `mdu_rs1`, `mdu_rs2`  out  XLEN  latched operands.
- `mdu_flush`  out  1  clears MDU state.
- `mdu_ready`  in  1  MDU result valid.
- `mdu_rd`  in  XLEN  MDU result.
- `wb_valid`  out  1  result valid to writeback.
- `wb_ready`  in  1  writeback accepts.
- `wb_rd_addr`  out  5  destination register.
- `wb_data`  out  XLEN  result.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, RUN, HOLD.
- **IDLE**
  - `s_ready=1`.
  - On `s_valid`, latch op, word, rs1, rs2 and rd_addr.
  - If the fast path hits, go to HOLD with the fast result. Otherwise go to RUN.
- **RUN**
  - `mdu_valid=1`.
  - On `mdu_ready`:
    - capture `mdu_rd` into `wb_data`, sign-extending `[31:0]` when `word=1`;
    - assert `mdu_flush` combinationally in the same cycle, which clears the MDU done flag;
    - go to HOLD.
- **HOLD**
  - `wb_valid=1`.
  - `wb_data` and `wb_rd_addr` are stable until accepted.
  - On `wb_ready`, go to IDLE. If `s_valid` is also high, accept the new op in the same cycle instead (`s_ready = wb_ready`) and go to RUN or HOLD.
- **Fast path** (div/divu/rem/remu only). Operands are the low 32 bits when `word=1`, else the full 64 bits.
  - Divisor zero: div/divu give all-ones; rem/remu give the dividend.
  - Signed overflow (div/rem, dividend = most-negative, divisor = -1): div gives the dividend; rem gives 0.
  - Word results are sign-extended from bit 31.
- Mul ops always go to the MDU.
- `mdu_*` operand outputs hold their last latched value outside RUN; only `mdu_valid` qualifies them.
- `flush`:
  - next state is IDLE from any state;
  - `mdu_flush=1` in that cycle;
  - `s_ready=0` in that cycle, so nothing is accepted;
  - any pending HOLD result is dropped.
- `g_reset` has priority over `flush`. Same effect, and all registers are cleared.

## Timing
- Reset values: state IDLE; `s_ready=1`; `mdu_valid=0`; `mdu_flush=0`; `wb_valid=0`; `busy=0`; `wb_data`, `wb_rd_addr` and latched operands are 0.
- Accept on edge N:
  - RUN: `mdu_valid` is high from N+1. If `mdu_ready` is first seen in cycle M, `wb_valid` is high from M+1.
  - Fast path: `wb_valid` is high from N+1.
- MDU latency for a 64-bit mul is 17 cycles at unroll 4. Accept-to-`wb_valid` is therefore MDU latency + 2.
- Back-to-back: a HOLD→RUN transition with no bubble is required when `wb_ready` and `s_valid` coincide.
- `mdu_flush` is a one-cycle pulse per completion. It is never asserted in IDLE unless `flush` or `g_reset` is high.
- No combinational path from `s_valid` to `wb_*`. The `wb_ready` → `s_ready` path is allowed.

## Structure
- Package `core_mdu_pkg` holds:
  - one-hot op bit index constants (`MDU_OP_MUL` … `MDU_OP_REMU`);
  - the FSM state enum;
  - the `MDU_OP_W = 8` width constant.
- Sub-module `core_mdu_fastpath` (combinational) takes op, word, rs1 and rs2 and returns `hit` and `result`.
- The top level holds only the FSM, the latches and the result sign-extension. Expected size is about 200 lines.

## Test plan
- **mul:** rs1=3, rs2=5, word=0 → `wb_data=15` one cycle after `mdu_ready`; exactly one `mdu_flush` pulse; `wb_rd_addr` matches.
- **mulw:** rs1=0x80000000, rs2=1 → `wb_data=0xFFFFFFFF_80000000`.
- **div by zero, no MDU issue:**
  - div 7/0 → `wb_data=0xFFFFFFFF_FFFFFFFF` at N+1, `mdu_valid` never high;
  - remu 7/0 → 7;
  - divuw 5/0 → 0xFFFFFFFF_FFFFFFFF.
- **Signed overflow:**
  - div 0x80000000_00000000 / -1 → 0x80000000_00000000;
  - rem → 0;
  - divw 0x80000000 / 0xFFFFFFFF → 0xFFFFFFFF_80000000.
- **Backpressure:**
  - hold `wb_ready=0` for 5 cycles in HOLD → `wb_data` stable, `s_ready=0`;
  - then `wb_ready=1` with `s_valid=1` → new op accepted in the same cycle, `mdu_valid` high the next cycle.
- **Flush and reset:**
  - `flush` mid-RUN → IDLE next cycle, `mdu_flush=1` that cycle, no `wb_valid`;
  - `flush` with `s_valid` in IDLE → not accepted;
  - `g_reset` in HOLD → `wb_valid=0` next cycle.
